// File: rtl/accum_pkg.sv
// accum_pkg: shared widths, FSM state encoding and the operand sign-extend
// helper for the accumulator control stage.
package accum_pkg;

  localparam int unsigned SW_W   = 8;  // switch operand width
  localparam int unsigned WORD_W = 9;  // adder / accumulator width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Two's-complement widening of an 8-bit switch value to the 9-bit word.
  function automatic logic [WORD_W-1:0] sign_ext(input logic [SW_W-1:0] v);
    return {v[SW_W-1], v};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: two-flop synchronizer followed by a counter debouncer for
// one raw push-button, plus a one-cycle pulse on each debounced press.
//
// Ports:
//   Clk      in   system clock
//   Reset    in   synchronous, active-high reset
//   btn_i    in   raw asynchronous button level
//   level_o  out  debounced button level
//   press_o  out  one-cycle pulse, high on the first cycle level_o is 1
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  // Keep at least one counter bit so DEBOUNCE_CYCLES = 1 still elaborates.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Count only while the synchronized level disagrees; any agreement
    // (a bounce back) restarts the count from zero.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/accum_ctrl_9.sv
// accum_ctrl_9: control and register stage around a 9-bit add/subtract
// ripple adder. Conditions the Run and Load_Clear buttons, snapshots the
// switch operand and function select, and captures the adder sum into the
// X:A accumulator with sticky signed-overflow tracking.
//
// Ports:
//   Clk     in   system clock
//   Reset   in   synchronous, active-high reset
//   run_i   in   raw Run button
//   load_i  in   raw Load_Clear button
//   sw_i    in   [7:0] switch operand, two's complement
//   fn_i    in   function select (0 add, 1 subtract)
//   sum_i   in   [8:0] adder sum
//   xa_o    out  [8:0] accumulator X:A (adder input a)
//   op_o    out  [8:0] registered sign-extended operand (not inverted)
//   fn_o    out  registered function select
//   busy_o  out  high whenever the FSM is not IDLE
//   done_o  out  one-cycle pulse when a new sum has been captured
//   ovf_o   out  sticky signed overflow, cleared by Load
module accum_ctrl_9
  import accum_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run_i,
  input  logic              load_i,
  input  logic [SW_W-1:0]   sw_i,
  input  logic              fn_i,
  input  logic [WORD_W-1:0] sum_i,
  output logic [WORD_W-1:0] xa_o,
  output logic [WORD_W-1:0] op_o,
  output logic              fn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o
);

  logic run_level;
  logic run_p;
  logic load_level_unused;
  logic load_p;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_btn (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_i   (run_i),
    .level_o (run_level),
    .press_o (run_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_btn (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_i   (load_i),
    .level_o (load_level_unused),
    .press_o (load_p)
  );

  state_t            state_q, state_d;
  logic [WORD_W-1:0] xa_q, xa_d;
  logic [WORD_W-1:0] op_q, op_d;
  logic              fn_q, fn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] b_eff;

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    op_d    = op_q;
    fn_d    = fn_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // Second adder operand as the adder actually sees it, for the sign test.
    b_eff   = op_q ^ {WORD_W{fn_q}};

    case (state_q)
      IDLE: begin
        if (load_p) begin
          xa_d  = sign_ext(sw_i);
          ovf_d = 1'b0;
        end else if (run_p) begin
          op_d    = sign_ext(sw_i);
          fn_d    = fn_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        xa_d    = sum_i;
        // Overflow: operands share a sign and the result's sign differs.
        ovf_d   = ovf_q | ((xa_q[WORD_W-1] == b_eff[WORD_W-1]) &&
                           (sum_i[WORD_W-1] != xa_q[WORD_W-1]));
        done_d  = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (load_p) begin
          xa_d  = sign_ext(sw_i);
          ovf_d = 1'b0;
        end
        if (!run_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      xa_q    <= '0;
      op_q    <= '0;
      fn_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign xa_o   = xa_q;
  assign op_o   = op_q;
  assign fn_o   = fn_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_accum_ctrl_9.sv
// tb_accum_ctrl_9: directed bench for accum_ctrl_9 with a 4-cycle debounce
// and a behavioural 9-bit add/subtract adder closing the loop.
module tb_accum_ctrl_9;

  logic       clk;
  logic       reset;
  logic       run_i;
  logic       load_i;
  logic [7:0] sw_i;
  logic       fn_i;
  logic [8:0] sum;
  logic [8:0] xa_o;
  logic [8:0] op_o;
  logic       fn_o;
  logic       busy_o;
  logic       done_o;
  logic       ovf_o;

  int checks = 0;
  int errors = 0;

  accum_ctrl_9 #(
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .Clk    (clk),
    .Reset  (reset),
    .run_i  (run_i),
    .load_i (load_i),
    .sw_i   (sw_i),
    .fn_i   (fn_i),
    .sum_i  (sum),
    .xa_o   (xa_o),
    .op_o   (op_o),
    .fn_o   (fn_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .ovf_o  (ovf_o)
  );

  // Adder model: a + (b ^ fn) + fn, modulo 512.
  always_comb sum = xa_o + (op_o ^ {9{fn_o}}) + {8'b0, fn_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus only: press Load, hold until captured (7 edges), release.
  task automatic do_load(input logic [7:0] sw);
    sw_i   = sw;
    load_i = 1'b1;
    tick(7);
    load_i = 1'b0;
    tick(8);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    if (xa_o !== 9'h000) begin errors++; $display("FAIL reset_xa: got %h expected %h", xa_o, 9'h000); end
    checks++;
    if (op_o !== 9'h000) begin errors++; $display("FAIL reset_op: got %h expected %h", op_o, 9'h000); end
    checks++;
    if ({fn_o, busy_o, done_o, ovf_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", {fn_o, busy_o, done_o, ovf_o}, 4'b0000);
    end
    checks++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_load;
    int busy_seen = 0;
    sw_i   = 8'h05;
    load_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (busy_o) busy_seen++;
    end
    if (xa_o !== 9'h005) begin errors++; $display("FAIL load_xa: got %h expected %h", xa_o, 9'h005); end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL load_ovf: got %b expected 0", ovf_o); end
    checks++;
    load_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy_o) busy_seen++;
    end
    if (busy_seen !== 0) begin errors++; $display("FAIL load_busy: busy cycles %0d expected 0", busy_seen); end
    checks++;
  endtask

  task automatic test_add;
    sw_i  = 8'h03;
    fn_i  = 1'b0;
    run_i = 1'b1;
    tick(6);  // run_p is asserted in this cycle
    if (busy_o !== 1'b0) begin errors++; $display("FAIL add_busy_pre: got %b expected 0", busy_o); end
    checks++;
    tick(1);
    if (op_o !== 9'h003 || fn_o !== 1'b0) begin
      errors++; $display("FAIL add_op: got op %h fn %b expected op %h fn 0", op_o, fn_o, 9'h003);
    end
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || xa_o !== 9'h005) begin
      errors++; $display("FAIL add_exec: got busy %b done %b xa %h expected 1 0 %h", busy_o, done_o, xa_o, 9'h005);
    end
    checks++;
    tick(1);
    if (xa_o !== 9'h008) begin errors++; $display("FAIL add_xa: got %h expected %h", xa_o, 9'h008); end
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", done_o); end
    checks++;
    tick(1);
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL add_done_end: got done %b busy %b expected 0 1", done_o, busy_o);
    end
    checks++;
    run_i = 1'b0;
    tick(8);
    if (busy_o !== 1'b0) begin errors++; $display("FAIL add_release: got busy %b expected 0", busy_o); end
    checks++;
  endtask

  task automatic test_sub_snapshot;
    sw_i  = 8'h0A;
    fn_i  = 1'b1;
    run_i = 1'b1;
    tick(7);  // now in EXEC
    if (op_o !== 9'h00A || fn_o !== 1'b1) begin
      errors++; $display("FAIL sub_op: got op %h fn %b expected op %h fn 1", op_o, fn_o, 9'h00A);
    end
    checks++;
    sw_i = 8'h55;
    fn_i = 1'b0;
    tick(1);
    if (xa_o !== 9'h1FE) begin errors++; $display("FAIL sub_xa: got %h expected %h", xa_o, 9'h1FE); end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL sub_ovf: got %b expected 0", ovf_o); end
    checks++;
    run_i = 1'b0;
    tick(8);
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    sw_i  = 8'h01;
    fn_i  = 1'b0;
    run_i = 1'b1;
    tick(1);
    run_i = 1'b0;
    tick(1);
    run_i = 1'b1;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (done_o) dones++;
    end
    if (xa_o !== 9'h1FF) begin errors++; $display("FAIL b2b_xa: got %h expected %h", xa_o, 9'h1FF); end
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_held_busy: got %b expected 1", busy_o); end
    checks++;
    run_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (done_o) dones++;
    end
    if (dones !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_release: got busy %b expected 0", busy_o); end
    checks++;
    if (xa_o !== 9'h1FF) begin errors++; $display("FAIL b2b_xa_final: got %h expected %h", xa_o, 9'h1FF); end
    checks++;
  endtask

  task automatic test_overflow;
    logic [8:0] exp_xa [3];
    logic       exp_ovf [3];
    exp_xa[0] = 9'h0FE; exp_ovf[0] = 1'b0;
    exp_xa[1] = 9'h17D; exp_ovf[1] = 1'b1;
    exp_xa[2] = 9'h1FC; exp_ovf[2] = 1'b1;
    do_load(8'h7F);
    if (xa_o !== 9'h07F) begin errors++; $display("FAIL ovf_load_xa: got %h expected %h", xa_o, 9'h07F); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      sw_i  = 8'h7F;
      fn_i  = 1'b0;
      run_i = 1'b1;
      tick(8);
      if (xa_o !== exp_xa[i]) begin
        errors++; $display("FAIL ovf_xa_%0d: got %h expected %h", i, xa_o, exp_xa[i]);
      end
      checks++;
      if (ovf_o !== exp_ovf[i]) begin
        errors++; $display("FAIL ovf_flag_%0d: got %b expected %b", i, ovf_o, exp_ovf[i]);
      end
      checks++;
      run_i = 1'b0;
      tick(8);
    end
    do_load(8'h80);
    if (xa_o !== 9'h180 || ovf_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got xa %h ovf %b expected %h 0", xa_o, ovf_o, 9'h180);
    end
    checks++;
  endtask

  task automatic test_reset_exec;
    int dones = 0;
    int busys = 0;
    sw_i  = 8'h02;
    fn_i  = 1'b0;
    run_i = 1'b1;
    tick(7);
    if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_exec_busy: got %b expected 1", busy_o); end
    checks++;
    reset = 1'b1;
    run_i = 1'b0;
    tick(1);
    if (xa_o !== 9'h000 || busy_o !== 1'b0 || done_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++; $display("FAIL rst_exec_state: got xa %h busy %b done %b ovf %b expected 000 0 0 0",
                         xa_o, busy_o, done_o, ovf_o);
    end
    checks++;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (done_o) dones++;
      if (busy_o) busys++;
    end
    if (dones !== 0 || busys !== 0) begin
      errors++; $display("FAIL rst_exec_quiet: got done %0d busy %0d cycles expected 0 0", dones, busys);
    end
    checks++;
  endtask

  task automatic test_load_run_same;
    int busys = 0;
    sw_i   = 8'h33;
    fn_i   = 1'b0;
    load_i = 1'b1;
    run_i  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy_o) busys++;
    end
    if (xa_o !== 9'h033) begin errors++; $display("FAIL same_xa: got %h expected %h", xa_o, 9'h033); end
    checks++;
    load_i = 1'b0;
    run_i  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy_o) busys++;
    end
    if (busys !== 0) begin errors++; $display("FAIL same_busy: got %0d busy cycles expected 0", busys); end
    checks++;
    if (op_o !== 9'h000 || xa_o !== 9'h033) begin
      errors++; $display("FAIL same_no_op: got op %h xa %h expected 000 %h", op_o, xa_o, 9'h033);
    end
    checks++;
  endtask

  initial begin
    reset  = 1'b1;
    run_i  = 1'b0;
    load_i = 1'b0;
    sw_i   = 8'h00;
    fn_i   = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_load;
    test_add;
    test_sub_snapshot;
    test_back_to_back;
    test_overflow;
    test_reset_exec;
    test_load_run_same;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
